// File: rtl/clock_divider.sv
// Binary ripple-free clock divider: a free-running counter whose bits
// are the divided clocks, bit i = fast_clock / 2^(i+1).
module clock_divider #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             fast_clock,
    input  logic             rst,
    output logic [WIDTH-1:0] slow_clock
);

    logic [WIDTH-1:0] r_count;

    // Outputs come straight off the flops so every bit is glitch-free
    // and changes only on a fast_clock rising edge.
    always_ff @(posedge fast_clock or negedge rst) begin
        if (!rst) begin
            r_count <= RESET_VALUE;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign slow_clock = r_count;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: async reset, counting, wrap,
// divider periods/duty, mid-count reset and reset toggling.
`timescale 1ns/1ps
module tb_clock_divider;

    logic       fast_clock;
    logic       rst;
    logic [9:0] slow_clock;
    logic       clk_en;

    int vectors;
    int miscompares;

    int     tog[10];
    longint last_rise[10];
    longint per[10];
    longint hi[10];
    bit     have_rise[10];
    int     edge_n;
    int     b9_rise_at;
    int     b9_fall_at;

    clock_divider #(
        .WIDTH      (10),
        .RESET_VALUE(10'h000)
    ) dut (
        .fast_clock(fast_clock),
        .rst       (rst),
        .slow_clock(slow_clock)
    );

    initial begin
        fast_clock = 1'b0;
        forever #10 fast_clock = clk_en ? ~fast_clock : fast_clock;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 10; i++) begin
            tog[i]       = 0;
            last_rise[i] = 0;
            per[i]       = 0;
            hi[i]        = 0;
            have_rise[i] = 1'b0;
        end
        edge_n     = 0;
        b9_rise_at = -1;
        b9_fall_at = -1;
    endtask

    task automatic tick(input int n);
        logic [9:0] p;
        for (int k = 0; k < n; k++) begin
            p = slow_clock;
            @(posedge fast_clock);
            #1;
            edge_n++;
            for (int i = 0; i < 10; i++) begin
                if (p[i] !== slow_clock[i]) begin
                    tog[i]++;
                    if (slow_clock[i]) begin
                        if (have_rise[i]) per[i] = $time - last_rise[i];
                        last_rise[i] = $time;
                        have_rise[i] = 1'b1;
                        if (i == 9) b9_rise_at = edge_n;
                    end else begin
                        if (have_rise[i]) hi[i] = $time - last_rise[i];
                        if (i == 9) b9_fall_at = edge_n;
                    end
                end
            end
        end
    endtask

    task automatic release_rst();
        rst = 1'b1;
        clear_stats();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_en      = 1'b0;
        rst         = 1'b1;
        clear_stats();

        // async reset with the clock stopped
        #5;
        rst = 1'b0;
        #1;
        check("async_rst_no_clk", slow_clock, 0);

        clk_en = 1'b1;
        tick(3);
        check("rst_hold_clk", slow_clock, 0);

        // count 5 from reset
        release_rst();
        tick(5);
        check("count5", slow_clock, 5);
        check("count5_bit0_tog", tog[0], 5);
        check("count5_bit1_tog", tog[1], 2);

        // wrap through 1023
        rst = 1'b0;
        #1;
        check("rst_before_wrap", slow_clock, 0);
        release_rst();
        tick(512);
        check("count512", slow_clock, 512);
        check("bit9_rise_edge", b9_rise_at, 512);
        tick(511);
        check("count1023", slow_clock, 1023);
        tick(1);
        check("wrap_to_0", slow_clock, 0);
        check("bit9_fall_edge", b9_fall_at, 1024);
        check("bit9_tog", tog[9], 2);

        // periods and duty over one more full cycle
        tick(1024);
        check("count_2048", slow_clock, 0);
        check("bit0_period_ns", per[0], 40);
        check("bit0_high_ns", hi[0], 20);
        check("bit3_period_ns", per[3], 320);
        check("bit3_high_ns", hi[3], 160);
        check("bit9_period_ns", per[9], 20480);
        check("bit9_high_ns", hi[9], 10240);

        // reset at count 1023
        tick(1023);
        check("count1023_b", slow_clock, 1023);
        #5;
        rst = 1'b0;
        #1;
        check("rst_at_1023", slow_clock, 0);

        // mid-count reset at 300
        release_rst();
        tick(300);
        check("count300", slow_clock, 300);
        #5;
        rst = 1'b0;
        #1;
        check("rst_at_300", slow_clock, 0);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check($sformatf("rst_hold_%0d", k), slow_clock, 0);
        end
        release_rst();
        tick(1);
        check("first_after_rel", slow_clock, 1);

        // reset toggling
        tick(99);
        check("high100", slow_clock, 100);
        rst = 1'b0;
        tick(50);
        check("low50", slow_clock, 0);
        release_rst();
        tick(100);
        check("resume100", slow_clock, 100);
        rst = 1'b0;
        tick(7);
        check("low7_again", slow_clock, 0);
        release_rst();
        tick(37);
        check("resume37", slow_clock, 37);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, giving the number of divided clock outputs.
REQ-002 The module SHALL have parameter RESET_VALUE, default 0, giving the value slow_clock takes while reset is active. It is WIDTH bits wide.
REQ-003 The module SHALL have port fast_clock, input, 1 bit: the single source clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port slow_clock, output, WIDTH bits (10 by default): the vector of divided clocks, bit i = fast_clock divided by 2^(i+1).
REQ-006 The design SHALL use one clock (fast_clock) only; no other clock or gated clock SHALL drive any register.

Function
REQ-007 The module SHALL hold a WIDTH-bit registered count; slow_clock SHALL be driven directly from these registers, with no combinational logic between register and port.
REQ-008 On every rising fast_clock edge with rst high, count SHALL increment by 1, modulo 2^WIDTH.
REQ-009 With default parameters, count 1023 SHALL wrap to 0 on the next edge, with no stall and no extra cycle.
REQ-010 slow_clock[i] SHALL toggle exactly every 2^i fast_clock rising edges.
- Period of bit i: 2^(i+1) fast cycles.
- Duty cycle: exactly 50%.
REQ-011 slow_clock[0] SHALL toggle on every rising fast_clock edge, so its frequency is fast_clock/2.
REQ-012 slow_clock[WIDTH-1] SHALL have period 2^WIDTH fast cycles (1024 by default).
REQ-013 All bits SHALL be phase-aligned: every bit changes only on a fast_clock rising edge, and bit i+1 toggles only on edges where bits 0..i all go 1->0.
REQ-014 Latency: the first increment SHALL occur on the first rising fast_clock edge sampled with rst high after reset release.
REQ-015 The module SHALL have no enable, load or handshake; counting SHALL be free-running whenever rst is high.

Reset
REQ-016 When rst goes low, slow_clock SHALL go to RESET_VALUE (all zeros by default) immediately, without waiting for a fast_clock edge.
REQ-017 While rst is low, slow_clock SHALL hold RESET_VALUE regardless of fast_clock activity.
REQ-018 Reset asserted mid-count, including at count 1023, SHALL abort counting with no partial or glitch value visible after the asynchronous clear.
REQ-019 After rst rises, counting SHALL resume from RESET_VALUE on the next rising fast_clock edge.
REQ-020 Repeated assert/release cycles SHALL each restart from RESET_VALUE, with no state retained.
REQ-021 Before the first reset, output values SHALL be unspecified; the bench SHALL apply reset before checking.

Verification
REQ-022 Async reset:
- Stimulus: rst low while fast_clock is stopped.
- Required: slow_clock = 10'h000 immediately, with no clock edge.
REQ-023 Count from reset:
- Stimulus: release rst, then apply 5 rising edges.
- Required: slow_clock = 10'd5.
- Check: bit0 toggled 5 times, bit1 toggled twice.
REQ-024 Wrap:
- Stimulus: release rst, then apply 1024 rising edges.
- Required: slow_clock = 10'd0.
- Check: bit9 rose once, at edge 512, and fell at edge 1024.
REQ-025 Divider ratios, with fast_clock period 20 ns:
- bit0 period = 40 ns.
- bit3 period = 320 ns.
- bit9 period = 20.48 us.
- Every bit's duty cycle = 50%.
REQ-026 Mid-count reset:
- Stimulus: at count 300, drive rst low between clock edges.
- Required: slow_clock = 0 immediately, and it holds 0 for 10 edges while rst is low.
- Required after release: one edge gives 1.
REQ-027 Reset toggling:
- Stimulus: hold rst high for 100 cycles, drive it low for 50 cycles, then drive it high again.
- Required: count resumes from 0, and the value 100 cycles after the second release = 100.
